// File: rtl/npu_pkg.sv
// npu_pkg: shared widths, requantizer config bundle and output clamp helper.
// IN_W/OUT_W match the ACC_WIDTH/DATA_WIDTH defaults of width.svh.
package npu_pkg;

  localparam int IN_W = 16;
  localparam int OUT_W = 8;

  localparam int SCALE_W = 16;
  localparam int SHIFT_W = 5;
  localparam int P_W = IN_W + SCALE_W + 1;
  localparam int R_W = P_W + 1;
  localparam int Z_W = R_W + 1;

  typedef struct packed {
    logic [SCALE_W-1:0]      scale;
    logic [SHIFT_W-1:0]      shift;
    logic signed [OUT_W-1:0] zp;
  } requant_cfg_t;

  typedef struct packed {
    logic             sat;
    logic [OUT_W-1:0] val;
  } clamp_t;

  function automatic clamp_t sat_clamp(
    input logic signed [Z_W-1:0] z
  );
    logic signed [Z_W-1:0] hi;
    logic signed [Z_W-1:0] lo;
    clamp_t c;
    hi = Z_W'(2 ** (OUT_W - 1) - 1);
    lo = ~hi;
    if (z > hi) begin
      c.sat = 1'b1;
      c.val = hi[OUT_W-1:0];
    end else if (z < lo) begin
      c.sat = 1'b1;
      c.val = lo[OUT_W-1:0];
    end else begin
      c.sat = 1'b0;
      c.val = z[OUT_W-1:0];
    end
    return c;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of multiply (S1), round/shift (S2), offset/clamp (S3).
// Stage enables come from the shared handshake in the top level.
module requant_lane
  import npu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en1,
  input  logic                     en2,
  input  logic                     en3,
  input  logic signed [IN_W-1:0]   din,
  input  logic [SCALE_W-1:0]       scale,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic signed [OUT_W-1:0]  zp,
  output logic [OUT_W-1:0]         dout,
  output logic                     sat
);

  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   p1;
  logic [SHIFT_W-1:0]      sh1;
  logic signed [OUT_W-1:0] zp1;
  logic signed [R_W-1:0]   half;
  logic signed [R_W-1:0]   sum;
  logic signed [R_W-1:0]   rsh;
  logic signed [R_W-1:0]   r2;
  logic signed [OUT_W-1:0] zp2;
  logic signed [Z_W-1:0]   z;
  clamp_t                  c;

  assign prod = P_W'(din) * P_W'($signed({1'b0, scale}));

  // half is 2^(shift-1), and 0 for shift 0 so r passes through unchanged
  always_comb begin
    half = (R_W'(1) << sh1) >> 1;
    sum  = R_W'(p1) + half;
    rsh  = sum >>> sh1;
  end

  always_comb begin
    z = Z_W'(r2) + Z_W'(zp2);
    c = sat_clamp(z);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1  <= '0;
      sh1 <= '0;
      zp1 <= '0;
    end else if (en1) begin
      p1  <= prod;
      sh1 <= shift;
      zp1 <= zp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2  <= '0;
      zp2 <= '0;
    end else if (en2) begin
      r2  <= rsh;
      zp2 <= zp1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      sat  <= 1'b0;
    end else if (en3) begin
      dout <= c.val;
      sat  <= c.sat;
    end
  end

endmodule

// File: rtl/requantizer.sv
// requantizer: LANES-wide 3-stage requantizer with valid/ready streaming.
// REQUANT_SAT_COUNT_EN adds per-lane saturation counters (sat_count, sat_clr).
module requantizer
  import npu_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES-1:0][IN_W-1:0]    in_data,
  input  logic [SCALE_W-1:0]            cfg_scale,
  input  logic [SHIFT_W-1:0]            cfg_shift,
  input  logic [OUT_W-1:0]              cfg_zp,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES-1:0][OUT_W-1:0]   out_data
`ifdef REQUANT_SAT_COUNT_EN
  ,
  output logic [LANES-1:0][15:0]        sat_count,
  input  logic                          sat_clr
`endif
);

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic [LANES-1:0] sat;
  requant_cfg_t cfg;

  assign cfg = '{scale: cfg_scale, shift: cfg_shift, zp: cfg_zp};

  // a stage loads when empty or when its contents move on this cycle
  assign en3 = !v3 || out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;

  assign in_ready  = en1;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    requant_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en1   (en1 && in_valid),
      .en2   (en2 && v1),
      .en3   (en3 && v2),
      .din   (in_data[l]),
      .scale (cfg.scale),
      .shift (cfg.shift),
      .zp    (cfg.zp),
      .dout  (out_data[l]),
      .sat   (sat[l])
    );
  end

`ifdef REQUANT_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      for (int l = 0; l < LANES; l++) begin
        if (sat[l] && sat_count[l] != 16'hFFFF)
          sat_count[l] <= sat_count[l] + 16'd1;
      end
    end
  end
`else
  logic unused_sat;
  assign unused_sat = &sat;
`endif

endmodule
